// File: rtl/hazard_controller_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM states, forward
// selects, drain length and the operand-match helpers. FORWARDING_EN selects forwarding mode.
package hazard_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_HALTED  = 2'd2
    } state_e;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_MEM   = 2'b01;
    localparam logic [1:0] FWD_WB    = 2'b10;

    localparam logic [2:0] DRAIN_LEN = 3'd4;

    // $0 is hardwired zero, so it never carries a dependency.
    function automatic logic src_hit(input logic       use_src,
                                     input logic [4:0] src,
                                     input logic       wr_en,
                                     input logic [4:0] dst);
        return use_src && (src != 5'd0) && wr_en && (src == dst);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       we_mem,
                                           input logic [4:0] dst_mem,
                                           input logic       we_wb,
                                           input logic [4:0] dst_wb);
        logic [1:0] sel;
        sel = FWD_NONE;
        if (src_hit(1'b1, src, we_mem, dst_mem))
            sel = FWD_MEM;
        else if (src_hit(1'b1, src, we_wb, dst_wb))
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-side signal bundle of the hazard controller; the fwdA_o/fwdB_o
// selects exist only when FORWARDING_EN is defined.
interface hazard_controller_if;
    logic [4:0]  rsD_i;
    logic [4:0]  rtD_i;
    logic        useRsD_i;
    logic        useRtD_i;
    logic        regWriteEx_i;
    logic        memToReadEx_i;
    logic [4:0]  writeAddrEx_i;
    logic [4:0]  rsEx_i;
    logic [4:0]  rtEx_i;
    logic        regWriteMem_i;
    logic [4:0]  writeAddrMem_i;
    logic        regWriteWb_i;
    logic [4:0]  writeAddrWb_i;
    logic        pcSrc_i;
    logic        haltReq_i;
    logic        resume_i;
    logic        clrCnt_i;
    logic        pcWrite_o;
    logic        fdWrite_o;
    logic        fdFlush_o;
    logic        deFlush_o;
    logic        emFlush_o;
    logic        halted_o;
    logic [15:0] stallCnt_o;
    logic [15:0] flushCnt_o;
`ifdef FORWARDING_EN
    logic [1:0]  fwdA_o;
    logic [1:0]  fwdB_o;
`endif

    modport master (
        output rsD_i, rtD_i, useRsD_i, useRtD_i,
               regWriteEx_i, memToReadEx_i, writeAddrEx_i, rsEx_i, rtEx_i,
               regWriteMem_i, writeAddrMem_i, regWriteWb_i, writeAddrWb_i,
               pcSrc_i, haltReq_i, resume_i, clrCnt_i,
        input  pcWrite_o, fdWrite_o, fdFlush_o, deFlush_o, emFlush_o,
               halted_o, stallCnt_o, flushCnt_o
`ifdef FORWARDING_EN
             , fwdA_o, fwdB_o
`endif
    );

    modport slave (
        input  rsD_i, rtD_i, useRsD_i, useRtD_i,
               regWriteEx_i, memToReadEx_i, writeAddrEx_i, rsEx_i, rtEx_i,
               regWriteMem_i, writeAddrMem_i, regWriteWb_i, writeAddrWb_i,
               pcSrc_i, haltReq_i, resume_i, clrCnt_i,
        output pcWrite_o, fdWrite_o, fdFlush_o, deFlush_o, emFlush_o,
               halted_o, stallCnt_o, flushCnt_o
`ifdef FORWARDING_EN
             , fwdA_o, fwdB_o
`endif
    );
endinterface

// File: rtl/hazard_controller_sat_counter16.sv
// 16-bit event counter that sticks at all-ones; clear wins over increment.
module sat_counter16 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [15:0] count_o
);
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = 16'd0;
        else if (inc_i && (count_q != 16'hFFFF))
            count_d = count_q + 16'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            count_q <= 16'd0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;
endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: stalls, branch flushes, debug halt drain and
// stall/flush statistics. FORWARDING_EN enables EX operand forwarding.
module hazard_controller
    import hazard_controller_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    hazard_controller_if.slave hz
);
    state_e      state_q, state_d;
    logic [2:0]  drain_q, drain_d;
    logic        rs_ex_hit, rt_ex_hit;
    logic        hazard;
    logic        stall_evt;
    logic        pc_write, fd_write, fd_flush, de_flush, em_flush, halted;
    logic [15:0] stall_cnt, flush_cnt;

    assign rs_ex_hit = src_hit(hz.useRsD_i, hz.rsD_i, hz.regWriteEx_i, hz.writeAddrEx_i);
    assign rt_ex_hit = src_hit(hz.useRtD_i, hz.rtD_i, hz.regWriteEx_i, hz.writeAddrEx_i);

`ifdef FORWARDING_EN
    // Only a load result is too late to forward into the next instruction.
    assign hazard = hz.memToReadEx_i && (rs_ex_hit || rt_ex_hit);

    assign hz.fwdA_o = rst_i ? FWD_NONE : fwd_sel(hz.rsEx_i, hz.regWriteMem_i, hz.writeAddrMem_i,
                                                  hz.regWriteWb_i, hz.writeAddrWb_i);
    assign hz.fwdB_o = rst_i ? FWD_NONE : fwd_sel(hz.rtEx_i, hz.regWriteMem_i, hz.writeAddrMem_i,
                                                  hz.regWriteWb_i, hz.writeAddrWb_i);
`else
    logic rs_mem_hit, rt_mem_hit;
    logic unused_fwd_inputs;

    assign rs_mem_hit = src_hit(hz.useRsD_i, hz.rsD_i, hz.regWriteMem_i, hz.writeAddrMem_i);
    assign rt_mem_hit = src_hit(hz.useRtD_i, hz.rtD_i, hz.regWriteMem_i, hz.writeAddrMem_i);
    assign hazard     = rs_ex_hit || rt_ex_hit || rs_mem_hit || rt_mem_hit;

    assign unused_fwd_inputs = ^{hz.memToReadEx_i, hz.rsEx_i, hz.rtEx_i,
                                 hz.regWriteWb_i, hz.writeAddrWb_i};
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            drain_q <= 3'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        pc_write  = 1'b1;
        fd_write  = 1'b1;
        fd_flush  = 1'b0;
        de_flush  = 1'b0;
        em_flush  = 1'b0;
        halted    = 1'b0;
        stall_evt = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (hz.haltReq_i && !hz.pcSrc_i) begin
                    state_d = ST_DRAIN;
                    drain_d = 3'd0;
                end
            end
            ST_DRAIN: begin
                pc_write = 1'b0;
                fd_flush = 1'b1;
                if (hz.pcSrc_i) begin
                    drain_d = 3'd0;
                end else begin
                    drain_d = drain_q + 3'd1;
                    if (drain_d == DRAIN_LEN)
                        state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                halted   = 1'b1;
                pc_write = 1'b0;
                fd_write = 1'b0;
                fd_flush = 1'b1;
                de_flush = 1'b1;
                em_flush = 1'b1;
                if (hz.resume_i)
                    state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                drain_d = 3'd0;
            end
        endcase

        // A taken branch squashes the dependent instruction, so its stall is moot.
        if (state_q != ST_HALTED) begin
            if (hz.pcSrc_i) begin
                pc_write = 1'b1;
                fd_flush = 1'b1;
                de_flush = 1'b1;
                em_flush = 1'b1;
            end else if (hazard) begin
                pc_write  = 1'b0;
                fd_write  = 1'b0;
                de_flush  = 1'b1;
                stall_evt = 1'b1;
            end
        end
    end

    assign hz.pcWrite_o = pc_write && !rst_i;
    assign hz.fdWrite_o = fd_write && !rst_i;
    assign hz.fdFlush_o = fd_flush || rst_i;
    assign hz.deFlush_o = de_flush || rst_i;
    assign hz.emFlush_o = em_flush || rst_i;
    assign hz.halted_o  = halted && !rst_i;

    sat_counter16 u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (hz.clrCnt_i),
        .inc_i   (stall_evt),
        .count_o (stall_cnt)
    );

    sat_counter16 u_flush_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (hz.clrCnt_i),
        .inc_i   (hz.pcSrc_i),
        .count_o (flush_cnt)
    );

    assign hz.stallCnt_o = stall_cnt;
    assign hz.flushCnt_o = flush_cnt;
endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: behavioural model compared every
// cycle plus directed vectors with literal expectations. Honors FORWARDING_EN.
module tb_hazard_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hazard_controller_if hz();
    hazard_controller dut (.clk_i(clk), .rst_i(rst), .hz(hz));

    int n_checks = 0;
    int n_errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit src_haz(input bit use_s, input logic [4:0] a,
                                   input bit we_ex, input bit ld_ex, input logic [4:0] d_ex,
                                   input bit we_mem, input logic [4:0] d_mem);
        bit h;
        h = 1'b0;
        if (use_s && a != 5'd0) begin
`ifdef FORWARDING_EN
            h = we_ex && ld_ex && (a == d_ex);
`else
            h = (we_ex && a == d_ex) || (we_mem && a == d_mem);
`endif
        end
        return h;
    endfunction

    function automatic int fwd_exp(input logic [4:0] a, input bit we_mem, input logic [4:0] d_mem,
                                   input bit we_wb, input logic [4:0] d_wb);
        if (a != 5'd0 && we_mem && a == d_mem) return 1;
        if (a != 5'd0 && we_wb && a == d_wb) return 2;
        return 0;
    endfunction

    logic m_haz;
    assign m_haz = src_haz(hz.useRsD_i, hz.rsD_i, hz.regWriteEx_i, hz.memToReadEx_i, hz.writeAddrEx_i,
                           hz.regWriteMem_i, hz.writeAddrMem_i)
                || src_haz(hz.useRtD_i, hz.rtD_i, hz.regWriteEx_i, hz.memToReadEx_i, hz.writeAddrEx_i,
                           hz.regWriteMem_i, hz.writeAddrMem_i);

    bit m_draining = 1'b0;
    bit m_halted   = 1'b0;
    int m_left     = 0;
    int m_stall    = 0;
    int m_flush    = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_draining <= 1'b0;
            m_halted   <= 1'b0;
            m_left     <= 0;
            m_stall    <= 0;
            m_flush    <= 0;
        end else begin
            if (hz.clrCnt_i) begin
                m_stall <= 0;
                m_flush <= 0;
            end else begin
                if (!m_halted && !hz.pcSrc_i && m_haz && m_stall < 65535) m_stall <= m_stall + 1;
                if (hz.pcSrc_i && m_flush < 65535) m_flush <= m_flush + 1;
            end
            if (m_halted) begin
                if (hz.resume_i) m_halted <= 1'b0;
            end else if (m_draining) begin
                if (hz.pcSrc_i) m_left <= 4;
                else if (m_left == 1) begin
                    m_draining <= 1'b0;
                    m_halted   <= 1'b1;
                end else m_left <= m_left - 1;
            end else if (hz.haltReq_i && !hz.pcSrc_i) begin
                m_draining <= 1'b1;
                m_left     <= 4;
            end
        end
    end

    // Outputs packed as {pcWrite, fdWrite, fdFlush, deFlush, emFlush, halted}.
    always @(negedge clk) begin : compare
        logic [5:0] exp_ctl;
        if (rst)             exp_ctl = 6'b00_111_0;
        else if (m_halted)   exp_ctl = 6'b00_111_1;
        else if (hz.pcSrc_i) exp_ctl = 6'b11_111_0;
        else                 exp_ctl = {!m_draining && !m_haz, !m_haz, m_draining, m_haz, 1'b0, 1'b0};
        check("model_ctrl", {hz.pcWrite_o, hz.fdWrite_o, hz.fdFlush_o, hz.deFlush_o, hz.emFlush_o, hz.halted_o},
              exp_ctl);
        check("model_stallCnt", hz.stallCnt_o, m_stall);
        check("model_flushCnt", hz.flushCnt_o, m_flush);
`ifdef FORWARDING_EN
        check("model_fwdA", hz.fwdA_o, rst ? 0 : fwd_exp(hz.rsEx_i, hz.regWriteMem_i, hz.writeAddrMem_i,
                                                           hz.regWriteWb_i, hz.writeAddrWb_i));
        check("model_fwdB", hz.fwdB_o, rst ? 0 : fwd_exp(hz.rtEx_i, hz.regWriteMem_i, hz.writeAddrMem_i,
                                                           hz.regWriteWb_i, hz.writeAddrWb_i));
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.rsD_i = 5'd0;          hz.rtD_i = 5'd0;
        hz.useRsD_i = 1'b0;       hz.useRtD_i = 1'b0;
        hz.regWriteEx_i = 1'b0;   hz.memToReadEx_i = 1'b0;
        hz.writeAddrEx_i = 5'd0;  hz.rsEx_i = 5'd0;  hz.rtEx_i = 5'd0;
        hz.regWriteMem_i = 1'b0;  hz.writeAddrMem_i = 5'd0;
        hz.regWriteWb_i = 1'b0;   hz.writeAddrWb_i = 5'd0;
        hz.pcSrc_i = 1'b0;        hz.haltReq_i = 1'b0;
        hz.resume_i = 1'b0;       hz.clrCnt_i = 1'b0;
    endtask

    task automatic load_use();
        hz.regWriteEx_i = 1'b1; hz.memToReadEx_i = 1'b1; hz.writeAddrEx_i = 5'd2;
        hz.rsD_i = 5'd2;        hz.useRsD_i = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: run still active at %0t, required to end earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        #1 rst = 1'b1;
        #1;
        check("rst_pcWrite", hz.pcWrite_o, 0);
        check("rst_flushes", {hz.fdFlush_o, hz.deFlush_o, hz.emFlush_o}, 3'b111);
        check("rst_stallCnt", hz.stallCnt_o, 0);
        tick(); tick();
        rst = 1'b0;
        tick(); #2;
        check("run_pcWrite", hz.pcWrite_o, 1);
        check("run_flushes", {hz.fdFlush_o, hz.deFlush_o, hz.emFlush_o}, 3'b000);

        // Load-use: one bubble.
        tick(); idle(); load_use(); #2;
        check("lu_pcWrite", hz.pcWrite_o, 0);
        check("lu_deFlush", hz.deFlush_o, 1);
        exp_stall++;
        tick(); idle(); #2;
        check("lu_stallCnt", hz.stallCnt_o, exp_stall);
        check("lu_resume_pc", hz.pcWrite_o, 1);

        // Matches that must never stall.
        tick(); idle(); load_use(); hz.useRsD_i = 1'b0; #2;
        check("nouse_pc", hz.pcWrite_o, 1);
        tick(); idle(); load_use(); hz.rsD_i = 5'd0; hz.writeAddrEx_i = 5'd0; #2;
        check("zero_reg_pc", hz.pcWrite_o, 1);
        tick(); idle(); hz.regWriteWb_i = 1'b1; hz.writeAddrWb_i = 5'd5; hz.rsD_i = 5'd5; hz.useRsD_i = 1'b1; #2;
        check("wb_match_pc", hz.pcWrite_o, 1);
        tick(); idle(); load_use(); hz.regWriteEx_i = 1'b0; #2;
        check("nowrite_pc", hz.pcWrite_o, 1);

        // ALU RAW.
`ifdef FORWARDING_EN
        tick(); idle(); hz.regWriteMem_i = 1'b1; hz.writeAddrMem_i = 5'd3; hz.rsEx_i = 5'd3; #2;
        check("raw_fwdA_mem", hz.fwdA_o, 2'b01);
        check("raw_nostall", hz.pcWrite_o, 1);
        hz.regWriteWb_i = 1'b1; hz.writeAddrWb_i = 5'd3; hz.rtEx_i = 5'd3; #1;
        check("raw_mem_wins", hz.fwdA_o, 2'b01);
        hz.writeAddrMem_i = 5'd9; #1;
        check("raw_fwdB_wb", hz.fwdB_o, 2'b10);
        tick(); idle(); hz.regWriteEx_i = 1'b1; hz.writeAddrEx_i = 5'd6; hz.rsD_i = 5'd6; hz.useRsD_i = 1'b1; #2;
        check("alu_ex_nostall", hz.pcWrite_o, 1);
`else
        tick(); idle(); hz.regWriteMem_i = 1'b1; hz.writeAddrMem_i = 5'd3; hz.rsD_i = 5'd3; hz.useRsD_i = 1'b1; #2;
        check("raw_mem_stall", hz.pcWrite_o, 0);
        exp_stall++;
        tick(); idle(); #2;
        check("raw_mem_done", hz.pcWrite_o, 1);
        tick(); idle(); hz.regWriteEx_i = 1'b1; hz.writeAddrEx_i = 5'd4; hz.rtD_i = 5'd4; hz.useRtD_i = 1'b1; #2;
        check("raw_ex_stall1", hz.pcWrite_o, 0);
        tick(); idle(); hz.regWriteMem_i = 1'b1; hz.writeAddrMem_i = 5'd4; hz.rtD_i = 5'd4; hz.useRtD_i = 1'b1; #2;
        check("raw_ex_stall2", hz.pcWrite_o, 0);
        exp_stall += 2;
        tick(); idle(); #2;
        check("raw_ex_done", hz.pcWrite_o, 1);
        check("raw_stallCnt", hz.stallCnt_o, exp_stall);
`endif

        // Branch flush overrides a coincident load-use stall.
        tick(); idle(); load_use(); hz.pcSrc_i = 1'b1; #2;
        check("br_flushes", {hz.fdFlush_o, hz.deFlush_o, hz.emFlush_o}, 3'b111);
        check("br_pcWrite", hz.pcWrite_o, 1);
        exp_flush++;
        tick(); idle(); #2;
        check("br_flushCnt", hz.flushCnt_o, exp_flush);
        check("br_stallCnt", hz.stallCnt_o, exp_stall);

        // Halt request pulse: four drain cycles, then halted.
        tick(); idle(); hz.haltReq_i = 1'b1; #2;
        check("hreq_pc", hz.pcWrite_o, 1);
        for (int i = 0; i < 4; i++) begin
            tick(); idle(); #2;
            check("drain_ctrl", {hz.pcWrite_o, hz.fdFlush_o, hz.halted_o}, 3'b010);
        end
        tick(); #2;
        check("halted_ctrl", {hz.pcWrite_o, hz.fdWrite_o, hz.emFlush_o, hz.halted_o}, 4'b0011);
        hz.resume_i = 1'b1;
        tick(); idle(); #2;
        check("resume_ctrl", {hz.pcWrite_o, hz.halted_o}, 2'b10);

        // Branch during drain restarts the drain count.
        tick(); idle(); hz.haltReq_i = 1'b1;
        tick(); idle();
        tick(); hz.pcSrc_i = 1'b1; #2;
        check("drain_br_pc", hz.pcWrite_o, 1);
        exp_flush++;
        tick(); idle();
        repeat (3) tick();
        #2;
        check("drain_br_still", {hz.pcWrite_o, hz.halted_o}, 2'b00);
        tick(); #2;
        check("drain_br_halted", hz.halted_o, 1);
        check("drain_br_flushCnt", hz.flushCnt_o, exp_flush);
        hz.resume_i = 1'b1;
        tick(); idle(); #2;
        check("drain_br_resume", hz.halted_o, 0);

        // Asynchronous reset mid-drain discards the halt.
        tick(); idle(); hz.haltReq_i = 1'b1;
        tick(); idle();
        tick();
        #1 rst = 1'b1;
        #1;
        check("arst_flushes", {hz.fdFlush_o, hz.deFlush_o, hz.emFlush_o}, 3'b111);
        check("arst_pc", {hz.pcWrite_o, hz.halted_o}, 2'b00);
        check("arst_stallCnt", hz.stallCnt_o, 0);
        #1 rst = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        tick(); #2;
        check("arst_run", {hz.pcWrite_o, hz.fdFlush_o, hz.halted_o}, 3'b100);

        // Saturation and clear priority.
        tick(); idle(); load_use();
        repeat (65535) @(posedge clk);
        #2;
        check("sat_preload", hz.stallCnt_o, 16'hFFFF);
        @(posedge clk); #2;
        check("sat_hold", hz.stallCnt_o, 16'hFFFF);
        hz.clrCnt_i = 1'b1;
        tick(); idle(); #2;
        check("sat_clear", hz.stallCnt_o, 0);
        check("sat_clear_flush", hz.flushCnt_o, exp_flush);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
